// File: rtl/trade_scheduler.sv
// Multi-channel front end for the shared day_trading evaluator: per-channel 3-day
// price history and ownership, round-robin grant of full windows onto one evaluator.

module trade_ch #(
  parameter int PRICE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 price_valid,
  input  logic [PRICE_W-1:0]   price_data,
  output logic                 price_ready,
  input  logic                 clr_pend,
  input  logic                 own_set,
  input  logic                 own_clr,
  output logic [3*PRICE_W-1:0] hist,
  output logic                 own
);
  logic [PRICE_W-1:0] day1, day2, day3;
  logic [1:0]         cnt;
  logic               pending;
  logic               accept;

  assign price_ready = !pending;
  assign accept      = price_valid && !pending;
  assign hist        = {day1, day2, day3};

  // A pending channel cannot accept, so clr_pend never collides with an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      day1 <= '0; day2 <= '0; day3 <= '0;
      cnt <= '0; pending <= 1'b0; own <= 1'b0;
    end else begin
      if (accept) begin
        day1 <= day2;
        day2 <= day3;
        day3 <= price_data;
        if (cnt != 2'd3) cnt <= cnt + 2'd1;
        if (cnt >= 2'd2) pending <= 1'b1;
      end else if (clr_pend) begin
        pending <= 1'b0;
      end
      if (own_set)      own <= 1'b1;
      else if (own_clr) own <= 1'b0;
    end
  end
endmodule

module trade_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PRICE_W  = 5,
  parameter int EVAL_LAT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               price_valid,
  input  logic [NUM_CH-1:0][PRICE_W-1:0]  price_data,
  output logic [NUM_CH-1:0]               price_ready,
  output logic [15:0]                     eval_stock_out,
  output logic                            eval_start,
  input  logic [15:0]                     eval_action_in,
  output logic                            act_valid,
  output logic [2:0]                      act_ch,
  output logic [15:0]                     act_code,
  output logic [NUM_CH-1:0]               own_out
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(EVAL_LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [NUM_CH-1:0]              pending, clr_pend, own_set, own_clr;
  logic [NUM_CH-1:0][3*PRICE_W-1:0] hist;
  logic [CHW-1:0]                 ptr, gnt, gnt_nxt, ci;
  logic [CW-1:0]                  wait_cnt;
  logic                           any_pend, grant, capture, code_buy, code_out;
  int                             idx;

  assign pending = ~price_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trade_ch #(.PRICE_W(PRICE_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .price_valid(price_valid[i]),
      .price_data (price_data[i]),
      .price_ready(price_ready[i]),
      .clr_pend   (clr_pend[i]),
      .own_set    (own_set[i]),
      .own_clr    (own_clr[i]),
      .hist       (hist[i]),
      .own        (own_out[i])
    );
  end

  // Round-robin: first pending channel at or after ptr, wrapping.
  always_comb begin
    any_pend = 1'b0;
    gnt_nxt  = '0;
    idx      = 0;
    ci       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      ci = CHW'(idx);
      if (!any_pend && pending[ci]) begin
        any_pend = 1'b1;
        gnt_nxt  = ci;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_pend) state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant    = (state == S_IDLE) && any_pend;
    capture  = (state == S_WAIT) && (wait_cnt == CW'(1));
    code_buy = (eval_action_in == 16'd3) || (eval_action_in == 16'd4) || (eval_action_in == 16'd7);
    code_out = (eval_action_in == 16'd1) || (eval_action_in == 16'd2);
    clr_pend = '0;
    own_set  = '0;
    own_clr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (capture && (gnt == CHW'(i))) begin
        clr_pend[i] = 1'b1;
        own_set[i]  = code_buy;
        own_clr[i]  = code_out;
      end
    end
  end

  // eval_action_in is only ever registered; nothing reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_stock_out <= '0;
      eval_start     <= 1'b0;
      act_valid      <= 1'b0;
      act_ch         <= '0;
      act_code       <= '0;
      ptr            <= '0;
      gnt            <= '0;
      wait_cnt       <= '0;
    end else begin
      eval_start <= grant;
      act_valid  <= capture;
      if (grant) begin
        eval_stock_out <= {own_out[gnt_nxt], hist[gnt_nxt]};
        gnt            <= gnt_nxt;
        wait_cnt       <= CW'(EVAL_LAT);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (capture) begin
        act_code <= eval_action_in;
        act_ch   <= 3'(gnt);
        ptr      <= (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + CHW'(1);
      end
    end
  end
endmodule

// File: tb/tb_trade_scheduler.sv
// Random + directed bench for trade_scheduler against a cycle-level behavioural model.

module tb_trade_scheduler;
  localparam int NUM_CH = 4, PRICE_W = 5, EVAL_LAT = 3;
  localparam int DW = NUM_CH * PRICE_W;
  localparam int DRAIN = NUM_CH * (EVAL_LAT + 1) + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [NUM_CH-1:0]    price_valid = '0, price_ready, own_out;
  logic [DW-1:0]        price_data = '0;
  logic [15:0]          eval_stock_out, eval_action_in = '0, act_code;
  logic                 eval_start, act_valid;
  logic [2:0]           act_ch;

  trade_scheduler #(.NUM_CH(NUM_CH), .PRICE_W(PRICE_W), .EVAL_LAT(EVAL_LAT)) dut (
    .clk(clk), .rst(rst),
    .price_valid(price_valid), .price_data(price_data), .price_ready(price_ready),
    .eval_stock_out(eval_stock_out), .eval_start(eval_start), .eval_action_in(eval_action_in),
    .act_valid(act_valid), .act_ch(act_ch), .act_code(act_code), .own_out(own_out)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model state: plain arrays, window kept oldest-first.
  logic [PRICE_W-1:0] m_h [NUM_CH][3];
  int                 m_cnt [NUM_CH];
  bit [NUM_CH-1:0]    m_pend, m_own;
  int                 m_ptr, m_left, m_g;
  bit                 m_busy, e_start, e_act;
  int                 e_ch;
  logic [15:0]        m_word, e_code;

  logic [15:0] codes [9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd8, 16'hFFFF};
  bit          use_force = 1'b1;
  logic [15:0] force_code = 16'd7;
  int          n_start = 0, n_act = 0;
  logic [15:0] last_word = '0, last_code = '0;
  int          order_q [$];
  logic [15:0] word_q [$];

  task automatic m_step();
    bit [NUM_CH-1:0] acc;
    int c;
    e_start = 1'b0;
    e_act   = 1'b0;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int d = 0; d < 3; d++) m_h[i][d] = '0;
        m_cnt[i] = 0;
      end
      m_pend = '0; m_own = '0; m_ptr = 0; m_busy = 1'b0; m_left = 0; m_word = '0;
    end else begin
      acc = price_valid & ~m_pend;
      if (!m_busy) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (m_ptr + k) % NUM_CH;
          if (!e_start && m_pend[c]) begin
            e_start = 1'b1;
            m_g     = c;
            m_word  = {m_own[c], m_h[c][0], m_h[c][1], m_h[c][2]};
            m_busy  = 1'b1;
            m_left  = EVAL_LAT;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          e_act  = 1'b1;
          e_ch   = m_g;
          e_code = eval_action_in;
          m_pend[m_g] = 1'b0;
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % NUM_CH;
          if (e_code == 16'd1 || e_code == 16'd2) m_own[m_g] = 1'b0;
          else if (e_code == 16'd3 || e_code == 16'd4 || e_code == 16'd7) m_own[m_g] = 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i]) begin
          m_h[i][0] = m_h[i][1];
          m_h[i][1] = m_h[i][2];
          m_h[i][2] = price_data[i*PRICE_W +: PRICE_W];
          if (m_cnt[i] < 3) m_cnt[i]++;
          if (m_cnt[i] == 3) m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    bit [NUM_CH-1:0] exp_rdy;
    @(posedge clk);
    m_step();
    #1;
    exp_rdy = ~m_pend;
    chk("price_ready", 32'(price_ready), 32'(exp_rdy));
    chk("eval_start", 32'(eval_start), 32'(e_start));
    chk("eval_stock_out", 32'(eval_stock_out), 32'(m_word));
    chk("act_valid", 32'(act_valid), 32'(e_act));
    if (e_act) begin
      chk("act_ch", 32'(act_ch), 32'(e_ch));
      chk("act_code", 32'(act_code), 32'(e_code));
    end
    chk("own_out", 32'(own_out), 32'(m_own));
    if (eval_start === 1'b1) begin
      n_start++;
      last_word = eval_stock_out;
      word_q.push_back(eval_stock_out);
      eval_action_in = use_force ? force_code : codes[$urandom_range(0, 8)];
    end
    if (act_valid === 1'b1) begin
      n_act++;
      last_code = act_code;
      order_q.push_back(int'(act_ch));
    end
  endtask

  task automatic drive(input logic [NUM_CH-1:0] m, input logic [PRICE_W-1:0] p);
    price_valid = m;
    price_data  = {NUM_CH{p}};
    cyc();
    price_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_start = 0; n_act = 0;
    order_q.delete(); word_q.delete();
  endtask

  int acc1;

  initial begin
    do_reset();
    cyc();

    // Basic window, then sliding window + sell on ch0
    force_code = 16'd7;
    repeat (3) drive(4'b0001, 5'd10);
    repeat (EVAL_LAT + 3) cyc();
    chk("s1_word", 32'(last_word), 32'h294A);
    chk("s1_code", 32'(last_code), 32'd7);
    chk("s1_own0", 32'(own_out[0]), 32'd1);
    force_code = 16'd1;
    drive(4'b0001, 5'd15);
    repeat (EVAL_LAT + 3) cyc();
    chk("s2_word", 32'(last_word), 32'hA94F);
    chk("s2_code", 32'(last_code), 32'd1);
    chk("s2_own0", 32'(own_out[0]), 32'd0);

    // Partial history on ch3
    do_reset();
    drive(4'b1000, 5'd20);
    drive(4'b1000, 5'd15);
    repeat (4) cyc();
    chk("s5_nostart", 32'(n_start), 32'd0);
    chk("s5_ready3", 32'(price_ready[3]), 32'd1);

    // Simultaneous windows ch0+ch2 (ptr=0), then ch0+ch3 (ptr=3)
    force_code = 16'd3;
    drive(4'b0101, 5'd1);
    drive(4'b0101, 5'd2);
    drive(4'b0101, 5'd3);
    repeat (DRAIN) cyc();
    chk("s3_n", 32'(order_q.size()), 32'd2);
    if (order_q.size() >= 2) begin
      chk("s3_first", 32'(order_q[0]), 32'd0);
      chk("s3_second", 32'(order_q[1]), 32'd2);
    end
    force_code = 16'd4;
    drive(4'b1001, 5'd10);
    repeat (DRAIN) cyc();
    chk("s3b_n", 32'(order_q.size()), 32'd4);
    if (order_q.size() >= 4) begin
      chk("s3b_first", 32'(order_q[2]), 32'd3);
      chk("s3b_second", 32'(order_q[3]), 32'd0);
      chk("s5_word", 32'(word_q[2]), 32'h51EA);
    end
    chk("s5_code", 32'(last_code), 32'd4);
    chk("s5_own3", 32'(own_out[3]), 32'd1);

    // Backpressure: ch1 valid held high with fresh data every cycle
    use_force = 1'b0;
    order_q.delete();
    acc1 = 0;
    for (int i = 0; i < 40; i++) begin
      price_valid = 4'b0010;
      price_data  = DW'($urandom);
      if (!m_pend[1]) acc1++;
      cyc();
    end
    price_valid = '0;
    repeat (DRAIN) cyc();
    chk("s4_evals", 32'(order_q.size()), 32'(acc1 - 2));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      price_valid = NUM_CH'($urandom);
      price_data  = DW'($urandom);
      cyc();
    end
    price_valid = '0;
    repeat (DRAIN) cyc();

    // Reset one cycle after eval_start abandons the evaluation
    use_force = 1'b1;
    force_code = 16'd7;
    do_reset();
    repeat (3) drive(4'b0001, 5'd5);
    for (int i = 0; i < 10 && n_start == 0; i++) cyc();
    chk("s6_start", 32'(n_start), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (8) cyc();
    chk("s6_noact", 32'(n_act), 32'd0);
    chk("s6_own", 32'(own_out), 32'd0);
    chk("s6_word", 32'(eval_stock_out), 32'd0);
    chk("s6_ready", 32'(price_ready), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
